// File: rtl/pattern_serializer.sv
// Parallel-to-serial shifter with a one-deep holding register, so a new word can be
// taken while the previous one is still being sent. Build option SER_LSB_FIRST_EN sends LSB first.
//
// state | meaning
// IDLE  | nothing on the serial line; waits for a held word
// SHIFT | sreg is on the line, one bit per cycle; cnt is the index of the bit being sent
module pattern_serializer #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          ser_data,
  output logic          ser_valid,
  output logic          sof
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_sreg;
  logic [DW-1:0] w_sreg_nxt;
  logic [DW-1:0] r_hold;
  logic          r_hold_vld;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_load;
  logic          w_accept;
  logic          w_last;
  logic          w_bit_nxt;
  logic          r_ser_data;
  logic          r_ser_valid;
  logic          r_sof;

  // Ready comes only from the registered holding flag, never from in_valid.
  assign in_ready = ~r_hold_vld;
  assign w_accept = in_valid & ~r_hold_vld;
  assign w_last   = (r_cnt == CW'(DW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sreg_nxt  = r_sreg;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_hold_vld) begin
          w_load = 1'b1;
        end
      end
      SHIFT: begin
        if (w_last) begin
          if (r_hold_vld) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
`ifdef SER_LSB_FIRST_EN
          w_sreg_nxt = {1'b0, r_sreg[DW-1:1]};
`else
          w_sreg_nxt = {r_sreg[DW-2:0], 1'b0};
`endif
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (w_load) begin
      w_sreg_nxt  = r_hold;
      w_cnt_nxt   = '0;
      w_state_nxt = SHIFT;
    end
  end

  // The output flop takes the bit that will sit at the head of sreg after this edge.
`ifdef SER_LSB_FIRST_EN
  assign w_bit_nxt = w_sreg_nxt[0];
`else
  assign w_bit_nxt = w_sreg_nxt[DW-1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg      <= '0;
      r_cnt       <= '0;
      r_hold      <= '0;
      r_hold_vld  <= 1'b0;
      r_ser_data  <= 1'b0;
      r_ser_valid <= 1'b0;
      r_sof       <= 1'b0;
    end else begin
      r_sreg <= w_sreg_nxt;
      r_cnt  <= w_cnt_nxt;
      if (w_accept) begin
        r_hold     <= in_data;
        r_hold_vld <= 1'b1;
      end else if (w_load) begin
        r_hold_vld <= 1'b0;
      end
      r_ser_valid <= (w_state_nxt == SHIFT);
      r_ser_data  <= (w_state_nxt == SHIFT) & w_bit_nxt;
      r_sof       <= w_load;
    end
  end

  assign ser_data  = r_ser_data;
  assign ser_valid = r_ser_valid;
  assign sof       = r_sof;

endmodule

// File: tb/tb_pattern_serializer.sv
// Scoreboard bench for pattern_serializer (DW=8): the driver queues the expected bit
// stream on each handshake, a negedge monitor pops and compares every payload bit.
module tb_pattern_serializer;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          ser_data;
  logic          ser_valid;
  logic          sof;

  typedef struct {
    logic d;
    logic s;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail = 0;
  int   run_len = 0;
  int   last_run = 0;
  logic [4:0] det_sh = '0;
  int   det_hits = 0;

  pattern_serializer #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ser_data  (ser_data),
    .ser_valid (ser_valid),
    .sof       (sof)
  );

  always #5 clk = ~clk;

  // Expected serial order of each test word, first bit in [7].
`ifdef SER_LSB_FIRST_EN
  localparam logic [7:0] S_D0 = 8'h0B, S_D8 = 8'h1B, S_1B = 8'hD8, S_AA = 8'h55,
                         S_55 = 8'hAA, S_F0 = 8'h0F, S_FF = 8'hFF, S_0F = 8'hF0,
                         S_3C = 8'h3C;
`else
  localparam logic [7:0] S_D0 = 8'hD0, S_D8 = 8'hD8, S_1B = 8'h1B, S_AA = 8'hAA,
                         S_55 = 8'h55, S_F0 = 8'hF0, S_FF = 8'hFF, S_0F = 8'h0F,
                         S_3C = 8'h3C;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      n_tests++;
      if (ser_valid) begin
        run_len++;
        det_sh = {det_sh[3:0], ser_data};
        if (det_sh == 5'b11011) det_hits++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_bit: got data=%0b sof=%0b, required no output", ser_data, sof);
        end else begin
          e = exp_q.pop_front();
          if (ser_data !== e.d || sof !== e.s) begin
            n_fail++;
            $display("FAIL stream_bit: got data=%0b sof=%0b, required data=%0b sof=%0b",
                     ser_data, sof, e.d, e.s);
          end
        end
      end else begin
        if (run_len != 0) last_run = run_len;
        run_len = 0;
        if (ser_data !== 1'b0 || sof !== 1'b0) begin
          n_fail++;
          $display("FAIL idle_zero: got data=%0b sof=%0b, required 0 0", ser_data, sof);
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [7:0] seq);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles, required 1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    for (int i = 7; i >= 0; i--) exp_q.push_back('{d: seq[i], s: (i == 7)});
    #1;
    in_data  = ~d;
    in_valid = 1'b0;
    check("ready_low_after_accept", {31'b0, in_ready}, 32'd0);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    check("reset_ser_valid", {31'b0, ser_valid}, 32'd0);
    check("reset_ser_data", {31'b0, ser_data}, 32'd0);
    check("reset_sof", {31'b0, sof}, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(2);

    // single word and first-bit latency
    send(8'hD0, S_D0);
    @(negedge clk);
    check("latency_no_bit_yet", {31'b0, ser_valid}, 32'd0);
    @(negedge clk);
    check("latency_first_valid", {31'b0, ser_valid}, 32'd1);
    check("latency_first_sof", {31'b0, sof}, 32'd1);
    wait_cycles(12);
    check("single_run_len", last_run, 32'd8);
    check("single_done", {31'b0, ser_valid}, 32'd0);

    // back-to-back, gapless, detector sees 11011 twice
    det_sh = '0;
    det_hits = 0;
    send(8'hD8, S_D8);
    send(8'h1B, S_1B);
    wait_cycles(20);
    check("b2b_run_len", last_run, 32'd16);
    check("b2b_detector_hits", det_hits, 32'd2);

    // backpressure: three words queued behind a busy shifter
    send(8'hAA, S_AA);
    send(8'h55, S_55);
    send(8'hF0, S_F0);
    wait_cycles(30);
    check("bp_run_len", last_run, 32'd24);

    // underrun
    send(8'hFF, S_FF);
    wait_cycles(12);
    check("underrun_idle", {31'b0, ser_valid}, 32'd0);
    check("underrun_run_len", last_run, 32'd8);

    // reset mid-word with a second word held
    send(8'hFF, S_FF);
    send(8'h0F, S_0F);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    run_len = 0;
    #1;
    check("midreset_ser_valid", {31'b0, ser_valid}, 32'd0);
    check("midreset_ser_data", {31'b0, ser_data}, 32'd0);
    check("midreset_sof", {31'b0, sof}, 32'd0);
    check("midreset_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_reset_silent", {31'b0, ser_valid}, 32'd0);

    // recovery after reset
    last_run = 0;
    send(8'h3C, S_3C);
    wait_cycles(12);
    check("recover_run_len", last_run, 32'd8);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, required finish");
    $fatal(1, "watchdog");
  end

endmodule
